pipereg_elastic: RTL and testbench
==================================

Name: pipereg_elastic

Overview:
- Parametrised, multi-entry successor to the single-slot stage register between the issue/execute/writeback pipeline stages.
- Carries an opaque DATA_W-bit payload plus a ROB index per entry, with a valid/ready handshake on both sides.
- Its ready output is registered, which breaks the combinational ready chain between stages.
- Supports full flush and selective redirect flush: only entries younger than the redirecting instruction are killed.

Parameters:
- DATA_W, 64, payload width in bits (opaque bundle of pc, instr, control and result fields).
- DEPTH, 2, number of entries; power of two, >= 2.
- ROB_W, 7, ROB index width; MSB is the wrap flag, the low ROB_W-1 bits are the index.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  registered; 1 when occupancy < DEPTH at the start of the cycle.
- in_data  in  DATA_W  upstream payload.
- in_robidx  in  ROB_W  ROB index of the upstream beat.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  head payload.
- out_robidx  out  ROB_W  head ROB index.
- flush_all  in  1  kill every entry (exception/trap).
- redirect_valid  in  1  selective flush request.
- redirect_robidx  in  ROB_W  ROB index of the redirecting instruction.
- count  out  CNT_W  current occupancy.

Behaviour:
- Reset (synchronous, active-high): head=0, tail=0, count=0, out_valid=0, in_ready=1. out_data and out_robidx read 0 after reset; entry storage need not be cleared.
- Storage: circular buffer with head and tail pointers, each log2(DEPTH) bits and wrapping modulo DEPTH. Entries are held in age order, oldest at head.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- out_valid = (count != 0). out_data and out_robidx are driven combinationally from the head entry. Zero-cycle bypass is not allowed.
- Latency: a beat accepted at edge N is visible on the outputs after edge N (1 cycle) when the buffer was empty.
- in_ready = (count_q < DEPTH). It is not a function of out_ready in the same cycle.
- Full buffer with simultaneous out_fire: in_ready is still 0 that cycle. No enqueue into a full buffer.
- Normal cycle: enqueue on in_fire, dequeue on out_fire; both may happen in the same cycle, and count is unchanged when they do.
- Age compare: "younger(a,r)" = (a.flag == r.flag) ? (a.idx > r.idx) : (a.idx < r.idx). Equal indices are not younger.
- Redirect (redirect_valid=1, flush_all=0):
  - Each resident entry i is killed when younger(robidx[i], redirect_robidx).
  - Survivors form a prefix from head. New tail = head + survivors; new count = survivors, minus 1 if out_fire is also asserted.
  - The dequeue in the same cycle is still honoured, because the head is the oldest entry and any beat the consumer takes is its responsibility.
  - The incoming beat on in_fire is written only if it is not younger than redirect_robidx; otherwise it is dropped silently. The handshake still completes.
- flush_all (takes priority over redirect): next count=0, head=tail=0, the incoming beat is dropped, and out_valid=0 from the next cycle.
- reset has priority over flush_all.
- Pointer wrap: tail advancing past DEPTH-1 returns to 0. The survivor prefix computation must respect the wrap.
- No X on out_valid or count at any time after reset.

Test Plan:
- Stream without backpressure: DEPTH=2; in_valid=1 and out_ready=1 for 8 cycles with robidx 0..7 -> out_robidx 0..7 in order, each one cycle after entry; count never exceeds 1.
- Backpressure/full: out_ready=0, push robidx 3, 4 -> count=2, in_ready=0 on the next cycle; a third beat stays pending; out_ready=1 -> 3 then 4 leave, and in_ready returns to 1 one cycle after the first dequeue.
- Selective redirect with wrap: DEPTH=4; entries {flag1:126, flag1:127, flag0:0, flag0:1} (ROB_W=7 → idx 6 bits, use idx 62, 63, 0, 1 with the flag flipping); redirect at flag1:63 -> count=2, survivors 62 and 63; next pushes land at the correct wrapped tail.
- Redirect plus simultaneous enqueue and dequeue: entries {5, 6, 7}, redirect at 6, in_fire with robidx 8, out_fire -> after the edge only 6 remains, count=1, and 8 is dropped.
- flush_all plus in_fire in the same cycle with a full buffer -> count=0, out_valid=0, in_ready=1 the following cycle.
- Reset mid-stream: assert reset with count=3 -> count=0, out_valid=0, in_ready=1 on the next edge; ordering after reset restarts cleanly from a new push.

Source files
------------

// File: rtl/pipereg_elastic.sv
// Elastic multi-entry stage register with registered in_ready, full flush and
// selective (younger-than-redirect) flush. Entries are kept oldest-first from head.
module pipereg_elastic #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int ROB_W  = 7,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ROB_W-1:0]  in_robidx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ROB_W-1:0]  out_robidx,
  input  logic              flush_all,
  input  logic              redirect_valid,
  input  logic [ROB_W-1:0]  redirect_robidx,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [ROB_W-1:0]  r_rob  [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_in_ready;

  logic              w_in_fire;
  logic              w_out_valid;
  logic              w_out_fire;
  logic [CNT_W-1:0]  w_surv;
  logic              w_deq;
  logic              w_wr;
  logic [PTR_W-1:0]  w_wr_ptr;
  logic [PTR_W-1:0]  w_head_n;
  logic [PTR_W-1:0]  w_tail_n;
  logic [CNT_W-1:0]  w_count_n;

  // Wrap-flag aware age compare; equal indices are not younger.
  function automatic logic younger(input logic [ROB_W-1:0] a, input logic [ROB_W-1:0] r);
    if (a[ROB_W-1] == r[ROB_W-1]) begin
      younger = (a[ROB_W-2:0] > r[ROB_W-2:0]);
    end else begin
      younger = (a[ROB_W-2:0] < r[ROB_W-2:0]);
    end
  endfunction

  assign w_in_fire   = in_valid & r_in_ready;
  assign w_out_valid = (r_count != '0);
  assign w_out_fire  = w_out_valid & out_ready;

  // Length of the surviving prefix from head; stops at the first killed entry.
  always_comb begin
    logic             alive;
    logic [PTR_W-1:0] pos;
    w_surv = '0;
    alive  = 1'b1;
    pos    = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      pos = r_head + PTR_W'(i);
      if (alive && (CNT_W'(i) < r_count) && !younger(r_rob[pos], redirect_robidx)) begin
        w_surv = w_surv + CNT_W'(1);
      end else begin
        alive = 1'b0;
      end
    end
  end

  // Next pointer/occupancy selection: flush_all over redirect over normal flow.
  always_comb begin
    w_deq     = 1'b0;
    w_wr      = 1'b0;
    w_wr_ptr  = r_tail;
    w_head_n  = r_head;
    w_tail_n  = r_tail;
    w_count_n = r_count;
    if (flush_all) begin
      w_head_n  = '0;
      w_tail_n  = '0;
      w_count_n = '0;
    end else if (redirect_valid) begin
      // A dequeue only counts if the head itself survived.
      w_deq     = w_out_fire && (w_surv != '0);
      w_wr      = w_in_fire && !younger(in_robidx, redirect_robidx);
      w_wr_ptr  = r_head + PTR_W'(w_surv);
      w_tail_n  = w_wr_ptr + PTR_W'(w_wr);
      w_head_n  = r_head + PTR_W'(w_deq);
      w_count_n = w_surv - CNT_W'(w_deq) + CNT_W'(w_wr);
    end else begin
      w_deq     = w_out_fire;
      w_wr      = w_in_fire;
      w_wr_ptr  = r_tail;
      w_tail_n  = r_tail + PTR_W'(w_wr);
      w_head_n  = r_head + PTR_W'(w_deq);
      w_count_n = r_count - CNT_W'(w_deq) + CNT_W'(w_wr);
    end
  end

  // Control state; in_ready reflects next-cycle occupancy so it is never a function of out_ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_head     <= w_head_n;
      r_tail     <= w_tail_n;
      r_count    <= w_count_n;
      r_in_ready <= (w_count_n < CNT_W'(DEPTH));
    end
  end

  // Entry storage write.
  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_data[w_wr_ptr] <= in_data;
      r_rob[w_wr_ptr]  <= in_robidx;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = w_out_valid;
  assign out_data   = w_out_valid ? r_data[r_head] : '0;
  assign out_robidx = w_out_valid ? r_rob[r_head] : '0;
  assign count      = r_count;

endmodule

// File: tb/tb_pipereg_elastic.sv
// Directed bench: DEPTH=2 instance (a) for streaming/backpressure/flush,
// DEPTH=4 instance (b) for wrapped redirect, redirect+enq+deq and reset.
module tb_pipereg_elastic;

  localparam int DW = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          iv_a, ir_a, ov_a, or_a, fl_a, rv_a;
  logic [DW-1:0] id_a, od_a;
  logic [6:0]    irob_a, orob_a, rrob_a;
  logic [1:0]    cnt_a;

  logic          iv_b, ir_b, ov_b, or_b, fl_b, rv_b;
  logic [DW-1:0] id_b, od_b;
  logic [6:0]    irob_b, orob_b, rrob_b;
  logic [2:0]    cnt_b;

  pipereg_elastic #(.DATA_W(DW), .DEPTH(2), .ROB_W(7)) u_dut_a (
    .clock(clock), .reset(reset), .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
    .in_robidx(irob_a), .out_valid(ov_a), .out_ready(or_a), .out_data(od_a),
    .out_robidx(orob_a), .flush_all(fl_a), .redirect_valid(rv_a),
    .redirect_robidx(rrob_a), .count(cnt_a));

  pipereg_elastic #(.DATA_W(DW), .DEPTH(4), .ROB_W(7)) u_dut_b (
    .clock(clock), .reset(reset), .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
    .in_robidx(irob_b), .out_valid(ov_b), .out_ready(or_b), .out_data(od_b),
    .out_robidx(orob_b), .flush_all(fl_b), .redirect_valid(rv_b),
    .redirect_robidx(rrob_b), .count(cnt_b));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_a(input logic [6:0] rob);
    iv_a = 1'b1; irob_a = rob; id_a = {9'h1A5, rob};
  endtask

  task automatic push_b(input logic [6:0] rob);
    iv_b = 1'b1; irob_b = rob; id_b = {9'h0C3, rob};
  endtask

  initial begin
    reset = 1'b1;
    iv_a = 1'b0; or_a = 1'b0; fl_a = 1'b0; rv_a = 1'b0; id_a = '0; irob_a = '0; rrob_a = '0;
    iv_b = 1'b0; or_b = 1'b0; fl_b = 1'b0; rv_b = 1'b0; id_b = '0; irob_b = '0; rrob_b = '0;
    tick(); tick();
    reset = 1'b0;

    chk("rst_count", 32'(cnt_a), 32'd0);
    chk("rst_oval", 32'(ov_a), 32'd0);
    chk("rst_iready", 32'(ir_a), 32'd1);
    chk("rst_odata", 32'(od_a), 32'd0);
    chk("rst_orob", 32'(orob_a), 32'd0);

    // Streaming, no backpressure: each beat visible one cycle after entry.
    or_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      push_a(7'(k));
      tick();
      chk("stream_rob", 32'(orob_a), 32'(k));
      chk("stream_data", 32'(od_a), {16'd0, 9'h1A5, 7'(k)});
      chk("stream_cnt", 32'(cnt_a), 32'd1);
    end
    iv_a = 1'b0;
    tick();
    chk("stream_end_cnt", 32'(cnt_a), 32'd0);
    chk("stream_end_oval", 32'(ov_a), 32'd0);

    // Backpressure until full, then drain.
    or_a = 1'b0;
    push_a(7'd3); tick();
    chk("bp_cnt1", 32'(cnt_a), 32'd1);
    chk("bp_ir1", 32'(ir_a), 32'd1);
    push_a(7'd4); tick();
    chk("bp_cnt2", 32'(cnt_a), 32'd2);
    chk("bp_ir_full", 32'(ir_a), 32'd0);
    push_a(7'd5); tick();
    chk("bp_pending_cnt", 32'(cnt_a), 32'd2);
    chk("bp_pending_head", 32'(orob_a), 32'd3);
    chk("bp_pending_ir", 32'(ir_a), 32'd0);
    or_a = 1'b1; tick();
    chk("bp_deq1_rob", 32'(orob_a), 32'd4);
    chk("bp_deq1_cnt", 32'(cnt_a), 32'd1);
    chk("bp_deq1_ir", 32'(ir_a), 32'd1);
    tick();
    chk("bp_enq5_rob", 32'(orob_a), 32'd5);
    chk("bp_enq5_cnt", 32'(cnt_a), 32'd1);
    iv_a = 1'b0; tick();
    chk("bp_drain_cnt", 32'(cnt_a), 32'd0);

    // flush_all on a full buffer with an incoming beat offered.
    or_a = 1'b0;
    push_a(7'd10); tick();
    push_a(7'd11); tick();
    chk("fl_full_cnt", 32'(cnt_a), 32'd2);
    fl_a = 1'b1; push_a(7'd12); tick();
    fl_a = 1'b0; iv_a = 1'b0;
    chk("fl_cnt", 32'(cnt_a), 32'd0);
    chk("fl_oval", 32'(ov_a), 32'd0);
    chk("fl_ir", 32'(ir_a), 32'd1);
    tick();
    chk("fl_dropped_cnt", 32'(cnt_a), 32'd0);
    // flush_all while a beat actually fires: beat is dropped.
    push_a(7'd13); tick();
    fl_a = 1'b1; push_a(7'd14); tick();
    fl_a = 1'b0; iv_a = 1'b0;
    chk("fl_fire_cnt", 32'(cnt_a), 32'd0);

    // Move DEPTH=4 head to 2 so the redirect scenario wraps.
    or_b = 1'b1;
    push_b(7'd90); tick();
    push_b(7'd91); tick();
    iv_b = 1'b0; tick();
    chk("wrap_pre_cnt", 32'(cnt_b), 32'd0);
    or_b = 1'b0;
    push_b(7'h7E); tick();
    push_b(7'h7F); tick();
    push_b(7'h00); tick();
    push_b(7'h01); tick();
    iv_b = 1'b0;
    chk("wrap_full_cnt", 32'(cnt_b), 32'd4);
    chk("wrap_full_ir", 32'(ir_b), 32'd0);
    rv_b = 1'b1; rrob_b = 7'h7F; tick();
    rv_b = 1'b0;
    chk("redir_cnt", 32'(cnt_b), 32'd2);
    chk("redir_head", 32'(orob_b), 32'h7E);
    chk("redir_ir", 32'(ir_b), 32'd1);
    push_b(7'h02); tick();
    push_b(7'h03); tick();
    iv_b = 1'b0;
    chk("redir_refill_cnt", 32'(cnt_b), 32'd4);
    or_b = 1'b1;
    chk("redir_drain0", 32'(orob_b), 32'h7E); tick();
    chk("redir_drain1", 32'(orob_b), 32'h7F); tick();
    chk("redir_drain2", 32'(orob_b), 32'h02); tick();
    chk("redir_drain3", 32'(orob_b), 32'h03);
    chk("redir_drain3_data", 32'(od_b), {16'd0, 9'h0C3, 7'h03}); tick();
    chk("redir_drain_cnt", 32'(cnt_b), 32'd0);
    chk("redir_drain_oval", 32'(ov_b), 32'd0);

    // Redirect with simultaneous enqueue (younger, dropped) and dequeue.
    or_b = 1'b0;
    push_b(7'd5); tick();
    push_b(7'd6); tick();
    push_b(7'd7); tick();
    chk("rde_pre_cnt", 32'(cnt_b), 32'd3);
    rv_b = 1'b1; rrob_b = 7'd6; push_b(7'd8); or_b = 1'b1; tick();
    rv_b = 1'b0; iv_b = 1'b0;
    chk("rde_cnt", 32'(cnt_b), 32'd1);
    chk("rde_head", 32'(orob_b), 32'd6);
    chk("rde_oval", 32'(ov_b), 32'd1);
    tick();
    chk("rde_drain_cnt", 32'(cnt_b), 32'd0);

    // Reset mid-stream, then a clean restart.
    or_b = 1'b0;
    push_b(7'd20); tick();
    push_b(7'd21); tick();
    push_b(7'd22); tick();
    chk("mrst_pre_cnt", 32'(cnt_b), 32'd3);
    iv_b = 1'b0; reset = 1'b1; tick();
    reset = 1'b0;
    chk("mrst_cnt", 32'(cnt_b), 32'd0);
    chk("mrst_oval", 32'(ov_b), 32'd0);
    chk("mrst_ir", 32'(ir_b), 32'd1);
    chk("mrst_orob", 32'(orob_b), 32'd0);
    push_b(7'd30); tick();
    iv_b = 1'b0;
    chk("mrst_new_rob", 32'(orob_b), 32'd30);
    chk("mrst_new_cnt", 32'(cnt_b), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
